// File: rtl/seq_mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add MULT/MULTU and restoring DIV/DIVU, one bit per cycle.
// Optional build macro MDU_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module seq_mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;      // MUL: partial product; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_b;        // MUL: remaining multiplier bits; DIV: divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz_pend;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_by_zero;

    logic               w_start_ok;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   w_b_shr;
    logic               w_last;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_sign_a   = op[0] & A[WIDTH-1];
    assign w_sign_b   = op[0] & B[WIDTH-1];
    assign w_abs_a    = w_sign_a ? (~A + ONE_W) : A;
    assign w_abs_b    = w_sign_b ? (~B + ONE_W) : B;

    // Restoring-divide step: the shifted remainder needs one extra bit before the trial subtract
    assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_b_shr  = {1'b0, r_b[WIDTH-1:1]};

    // One iteration of the selected algorithm
    always_comb begin
        w_acc_step = r_acc;
        if (r_is_div) begin
            w_acc_step = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
        end else if (r_b[0]) begin
            w_acc_step = r_acc + r_mcand;
        end else begin
            w_acc_step = r_acc;
        end
    end

`ifdef MDU_EARLY_OUT_EN
    assign w_last = (r_count == LAST_CNT) || (!r_is_div && (w_b_shr == ZERO_W));
`else
    assign w_last = (r_count == LAST_CNT);
`endif

    // Sign fix-up of the final iteration's result
    always_comb begin
        w_mul_res = r_neg_q ? (~w_acc_step + ONE_2W) : w_acc_step;
        w_quo     = w_acc_step[WIDTH-1:0];
        w_rem     = w_acc_step[2*WIDTH-1:WIDTH];
        w_res_hi  = ZERO_W;
        w_res_lo  = ZERO_W;
        if (r_is_div) begin
            w_res_lo = r_dbz_pend ? ONES_W : (r_neg_q ? (~w_quo + ONE_W) : w_quo);
            w_res_hi = r_neg_r ? (~w_rem + ONE_W) : w_rem;
        end else begin
            w_res_hi = w_mul_res[2*WIDTH-1:WIDTH];
            w_res_lo = w_mul_res[WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture and iteration datapath; HI/LO only load on the final iteration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= {CW{1'b0}};
            r_acc         <= ZERO_2W;
            r_mcand       <= ZERO_2W;
            r_b           <= ZERO_W;
            r_is_div      <= 1'b0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dbz_pend    <= 1'b0;
            r_hi          <= ZERO_W;
            r_lo          <= ZERO_W;
            r_div_by_zero <= 1'b0;
        end else if (w_start_ok) begin
            r_count       <= {CW{1'b0}};
            r_acc         <= op[1] ? {ZERO_W, w_abs_a} : ZERO_2W;
            r_mcand       <= {ZERO_W, w_abs_a};
            r_b           <= w_abs_b;
            r_is_div      <= op[1];
            r_neg_q       <= w_sign_a ^ w_sign_b;
            r_neg_r       <= w_sign_a;
            r_dbz_pend    <= op[1] & (B == ZERO_W);
            r_div_by_zero <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_count <= r_count + CNT_ONE;
            r_acc   <= w_acc_step;
            if (!r_is_div) begin
                r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
                r_b     <= w_b_shr;
            end
            if (w_last) begin
                r_hi          <= w_res_hi;
                r_lo          <= w_res_lo;
                r_div_by_zero <= r_dbz_pend;
            end
        end
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign HI          = r_hi;
    assign LO          = r_lo;
    assign div_by_zero = r_div_by_zero;

endmodule
